temp_qsys_nios2_gen2_cpu_oci_dct_ctrl: RTL and testbench
========================================================

TEMP_QSYS_NIOS2_GEN2_CPU_OCI_DCT_CTRL -- requirements
Module: temp_qsys_nios2_gen2_cpu_oci_dct_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 Port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port `frame_valid`, input, 1 bit: a 2-bit trace frame is present this cycle.
REQ-005 Port `frame_data`, input, 2 bits: the trace frame.
REQ-006 Port `flush`, input, 1 bit: single-cycle request to emit a partial packet.
REQ-007 Port `test_ending`, input, 1 bit: level; starts the drain-and-end sequence.
REQ-008 Port `pkt_ready`, input, 1 bit: downstream accepts a packet.
REQ-009 Port `dct_buffer`, output, 30 bits: accumulation buffer, registered.
REQ-010 Port `dct_count`, output, 4 bits: number of frames in `dct_buffer` (0-15), registered.
REQ-011 Port `pkt_valid`, output, 1 bit: a packet is held for downstream.
REQ-012 Port `pkt_data`, output, 30 bits: packet payload.
REQ-013 Port `pkt_count`, output, 4 bits: number of frames in the packet.
REQ-014 Port `frame_drop`, output, 1 bit: one-cycle pulse when a frame is lost.
REQ-015 Port `test_has_ended`, output, 1 bit: sticky flag set once the drain is complete.
REQ-016 Port `ovf_count`, output, 8 bits: present only when `DCT_OVF_CNT_EN` is defined.

Function
REQ-017 Accumulation: define full = (`dct_count` == 15).
REQ-018 Frame shift: on `frame_valid` & ~full & ~xfer, `dct_buffer` SHALL load {`dct_buffer`[27:0], `frame_data`} and `dct_count` SHALL increment; the newest frame is always in the LSBs.
REQ-019 Flush request: a `flush` pulse SHALL set the internal register `flush_pend`; a frame accepted in the same cycle as `flush` SHALL be included in the flushed packet.
REQ-020 Transfer condition: xfer = (full | (`flush_pend` & `dct_count` != 0)) & (~`pkt_valid` | `pkt_ready`).
REQ-021 On xfer: `pkt_data` <= `dct_buffer`, `pkt_count` <= `dct_count`, `pkt_valid` <= 1, and `flush_pend` <= 0.
REQ-022 On xfer, the buffer SHALL restart: it loads {28'b0, `frame_data`} with count 1 if `frame_valid`, else all zeros with count 0; no frame is lost on a transfer cycle.
REQ-023 Packet handshake: a packet is consumed when `pkt_valid` & `pkt_ready`; `pkt_valid` SHALL clear on consumption unless xfer reloads it in the same cycle.
REQ-024 Packet stability: `pkt_data` and `pkt_count` SHALL be stable while `pkt_valid` is high and `pkt_ready` is low.
REQ-025 Frame loss: `frame_valid` & full & ~xfer SHALL drop the frame, pulse `frame_drop` for one cycle, and leave the buffer unchanged.
REQ-026 Empty flush: `flush_pend` with `dct_count` == 0 SHALL clear `flush_pend` with no packet.
REQ-027 FSM state RUN: normal operation as above.
REQ-028 FSM transition RUN -> DRAIN: on `test_ending` = 1.
REQ-029 FSM state DRAIN: `frame_valid` is ignored (no shift, no `frame_drop`) and `flush_pend` is forced to 1 each cycle.
REQ-030 FSM transition DRAIN -> ENDED: when `dct_count` == 0 & ~`pkt_valid`.
REQ-031 FSM state ENDED: `test_has_ended` = 1 and frames are ignored; ENDED is left only by reset.
REQ-032 A `test_ending` deassertion in DRAIN SHALL have no effect on the drain.
REQ-033 Latency: a frame that completes the 15th slot SHALL appear on `pkt_data` on the next cycle if the packet register is free.

Reset
REQ-034 Reset assertion SHALL take effect immediately and be independent of `clk`.
REQ-035 While `reset_n` is low, all outputs SHALL be 0 and the FSM SHALL be in RUN with `flush_pend` = 0.
REQ-036 Reset mid-packet SHALL discard the buffered and pending data, with no partial output after release.

Configuration
REQ-037 With the macro `DCT_OVF_CNT_EN` defined, `ovf_count` SHALL increment on each `frame_drop` and saturate at 255.
REQ-038 With `DCT_OVF_CNT_EN` undefined, neither the `ovf_count` port nor its logic SHALL exist; all other behaviour is identical.

Verification
REQ-039 Fill: 15 frames of 2'b01 with `pkt_ready` = 1 -> one cycle later `pkt_valid` = 1, `pkt_data` = 30'h15555555, `pkt_count` = 15, `dct_count` = 0.
REQ-040 Partial flush: frames 2'b11, 2'b10, 2'b01, with `flush` on the 3rd frame -> `pkt_data` = 30'h39, `pkt_count` = 3.
REQ-041 Backpressure: `pkt_ready` = 0, 31 frames -> the first packet is held stable, the second buffer fills, the 31st frame pulses `frame_drop` (and `ovf_count` = 1 if enabled); raising `pkt_ready` releases packet 2 on the next cycle.
REQ-042 Transfer plus frame: a frame arrives on the xfer cycle -> `dct_count` = 1 afterwards and no `frame_drop`.
REQ-043 Drain: 5 frames buffered, `test_ending` = 1, `pkt_ready` = 1 -> one packet with `pkt_count` = 5, then `test_has_ended` = 1; later frames are ignored.
REQ-044 Async reset: `reset_n` low mid-fill with `dct_count` = 7 -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/temp_qsys_nios2_gen2_cpu_oci_dct_ctrl_if.sv
// Trace frame in / packet out bundle for the OCI DCT controller.
// ovf_count exists only when DCT_OVF_CNT_EN is defined.
interface temp_qsys_nios2_gen2_cpu_oci_dct_ctrl_if;
  logic        frame_valid;
  logic [1:0]  frame_data;
  logic        flush;
  logic        test_ending;
  logic        pkt_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic [29:0] pkt_data;
  logic [3:0]  pkt_count;
  logic        frame_drop;
  logic        test_has_ended;
`ifdef DCT_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  modport slave (
    input  frame_valid, frame_data, flush,
    input  test_ending, pkt_ready,
    output dct_buffer, dct_count,
    output pkt_valid, pkt_data, pkt_count,
`ifdef DCT_OVF_CNT_EN
    output ovf_count,
`endif
    output frame_drop, test_has_ended
  );

  modport master (
    output frame_valid, frame_data, flush,
    output test_ending, pkt_ready,
    input  dct_buffer, dct_count,
    input  pkt_valid, pkt_data, pkt_count,
`ifdef DCT_OVF_CNT_EN
    input  ovf_count,
`endif
    input  frame_drop, test_has_ended
  );
endinterface

// File: rtl/temp_qsys_nios2_gen2_cpu_oci_dct_ctrl.sv
// Packs 2-bit trace frames into 15-frame packets with flush and drain.
// Optional saturating drop counter enabled by DCT_OVF_CNT_EN.
module temp_qsys_nios2_gen2_cpu_oci_dct_ctrl (
  input logic clk,
  input logic reset_n,
  temp_qsys_nios2_gen2_cpu_oci_dct_ctrl_if.slave dct
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pv_q, pv_d;
  logic [29:0] pd_q, pd_d;
  logic [3:0]  pc_q, pc_d;
  logic        drop_q, drop_d;

  logic full, run, drain, pend, xfer, acc;

  always_comb begin
    full  = (cnt_q == 4'd15);
    run   = (state_q == RUN);
    drain = (state_q == DRAIN);
    // draining behaves as a permanent flush request
    pend  = pend_q | drain;
    xfer  = (full | (pend & (cnt_q != 4'd0)))
          & (~pv_q | dct.pkt_ready);
    acc   = run & dct.frame_valid;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == RUN:
        if (dct.test_ending) state_d = DRAIN;
      state_q == DRAIN:
        if (cnt_q == 4'd0 && !pv_q) state_d = ENDED;
      default:
        state_d = state_q;
    endcase
  end

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    pv_d   = pv_q;
    pd_d   = pd_q;
    pc_d   = pc_q;
    drop_d = acc & full & ~xfer;
    pend_d = dct.flush | drain
           | (pend_q & ~xfer & (cnt_q != 4'd0));
    if (xfer) begin
      pd_d  = buf_q;
      pc_d  = cnt_q;
      pv_d  = 1'b1;
      buf_d = acc ? {28'b0, dct.frame_data} : 30'b0;
      cnt_d = acc ? 4'd1 : 4'd0;
    end else begin
      if (pv_q && dct.pkt_ready) pv_d = 1'b0;
      if (acc && !full) begin
        buf_d = {buf_q[27:0], dct.frame_data};
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      pc_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

`ifdef DCT_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_q <= '0;
    else if (drop_d && ovf_q != 8'hff)
      ovf_q <= ovf_q + 8'd1;
  end

  assign dct.ovf_count = ovf_q;
`endif

  assign dct.dct_buffer     = buf_q;
  assign dct.dct_count      = cnt_q;
  assign dct.pkt_valid      = pv_q;
  assign dct.pkt_data       = pd_q;
  assign dct.pkt_count      = pc_q;
  assign dct.frame_drop     = drop_q;
  assign dct.test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_temp_qsys_nios2_gen2_cpu_oci_dct_ctrl.sv
// Random and directed bench for the DCT controller against a
// queue-based packet model.
module tb_temp_qsys_nios2_gen2_cpu_oci_dct_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  temp_qsys_nios2_gen2_cpu_oci_dct_ctrl_if ifc();

  temp_qsys_nios2_gen2_cpu_oci_dct_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dct     (ifc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model: buffer is a list of frames, oldest first
  bit [1:0]  mq[$];
  bit        m_pv;
  bit [29:0] m_pd;
  bit [3:0]  m_pc;
  bit        m_pend;
  int        m_mode;
  bit        m_drop;
  int        m_ovf;

  function automatic bit [29:0] pack_q();
    bit [29:0] v = '0;
    foreach (mq[i]) v = v * 4 + 30'(mq[i]);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pv = 0; m_pd = 0; m_pc = 0;
    m_pend = 0; m_mode = 0; m_drop = 0; m_ovf = 0;
  endtask

  task automatic model_step(bit fv, bit [1:0] fd, bit fl,
                            bit te, bit rdy);
    int  n    = mq.size();
    bit  pe   = m_pend || (m_mode == 1);
    bit  acc  = fv && (m_mode == 0);
    bit  xf   = ((n == 15) || (pe && n != 0)) && (!m_pv || rdy);
    int  nm   = m_mode;
    if (m_mode == 0 && te) nm = 1;
    if (m_mode == 1 && n == 0 && !m_pv) nm = 2;
    m_drop = acc && (n == 15) && !xf;
    if (m_drop && m_ovf < 255) m_ovf++;
    if (fl || m_mode == 1) m_pend = 1;
    else if (xf || n == 0) m_pend = 0;
    if (xf) begin
      m_pd = pack_q();
      m_pc = 4'(n);
      m_pv = 1;
      mq.delete();
      if (acc) mq.push_back(fd);
    end else begin
      if (m_pv && rdy) m_pv = 0;
      if (acc && n < 15) mq.push_back(fd);
    end
    m_mode = nm;
  endtask

  task automatic compare_all();
    chk("dct_buffer", 32'(ifc.dct_buffer), 32'(pack_q()));
    chk("dct_count", 32'(ifc.dct_count), 32'(mq.size()));
    chk("pkt_valid", 32'(ifc.pkt_valid), 32'(m_pv));
    chk("pkt_data", 32'(ifc.pkt_data), 32'(m_pd));
    chk("pkt_count", 32'(ifc.pkt_count), 32'(m_pc));
    chk("frame_drop", 32'(ifc.frame_drop), 32'(m_drop));
    chk("ended", 32'(ifc.test_has_ended), 32'(m_mode == 2));
`ifdef DCT_OVF_CNT_EN
    chk("ovf_count", 32'(ifc.ovf_count), 32'(m_ovf));
`endif
  endtask

  task automatic step(bit fv, bit [1:0] fd, bit fl, bit te, bit rdy);
    ifc.frame_valid = fv;
    ifc.frame_data  = fd;
    ifc.flush       = fl;
    ifc.test_ending = te;
    ifc.pkt_ready   = rdy;
    model_step(fv, fd, fl, te, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    ifc.frame_valid = 0;
    ifc.frame_data  = 0;
    ifc.flush       = 0;
    ifc.test_ending = 0;
    ifc.pkt_ready   = 0;
    reset_n = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    reset_n = 1;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    do_reset();

    // fill: fifteen 01 frames, then the packet appears
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0, 1);
    chk("fill_cnt15", 32'(ifc.dct_count), 32'd15);
    step(0, 0, 0, 0, 1);
    chk("fill_pv", 32'(ifc.pkt_valid), 32'd1);
    chk("fill_data", 32'(ifc.pkt_data), 32'h15555555);
    chk("fill_pc", 32'(ifc.pkt_count), 32'd15);
    chk("fill_cnt0", 32'(ifc.dct_count), 32'd0);

    // partial flush with the flush on the third frame
    do_reset();
    step(1, 2'b11, 0, 0, 1);
    step(1, 2'b10, 0, 0, 1);
    step(1, 2'b01, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("flush_data", 32'(ifc.pkt_data), 32'h39);
    chk("flush_pc", 32'(ifc.pkt_count), 32'd3);

    // backpressure: 31 frames with nobody reading
    do_reset();
    for (int i = 0; i < 31; i++)
      step(1, 2'($urandom_range(0, 3)), 0, 0, 0);
    chk("bp_drop", 32'(ifc.frame_drop), 32'd1);
    chk("bp_cnt", 32'(ifc.dct_count), 32'd15);
    step(0, 0, 0, 0, 1);
    chk("bp_pv", 32'(ifc.pkt_valid), 32'd1);
    chk("bp_pc", 32'(ifc.pkt_count), 32'd15);

    // transfer cycle with a frame arriving
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 2'b10, 0, 0, 1);
    step(1, 2'b11, 0, 0, 1);
    chk("xf_cnt", 32'(ifc.dct_count), 32'd1);
    chk("xf_nodrop", 32'(ifc.frame_drop), 32'd0);

    // drain: test_ending dropped after one cycle
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 2'b01, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 2'b11, 0, 0, 1);
    chk("drain_pv", 32'(ifc.pkt_valid), 32'd1);
    chk("drain_pc", 32'(ifc.pkt_count), 32'd5);
    for (int i = 0; i < 20 && !ifc.test_has_ended; i++)
      step(0, 0, 0, 0, 1);
    chk("drain_end", 32'(ifc.test_has_ended), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 2'b10, 0, 0, 1);
    chk("ended_cnt", 32'(ifc.dct_count), 32'd0);

    // async reset mid-fill, off the clock edge
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 2'b11, 0, 0, 1);
    #2 reset_n = 0;
    #1;
    chk("ar_buf", 32'(ifc.dct_buffer), 32'd0);
    chk("ar_cnt", 32'(ifc.dct_count), 32'd0);
    chk("ar_pv", 32'(ifc.pkt_valid), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    // random episodes
    for (int e = 0; e < 6; e++) begin
      do_reset();
      for (int i = 0; i < 400; i++)
        step(($urandom_range(0, 9) < 7),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 299) == 0),
             ($urandom_range(0, 9) < (e % 2 ? 3 : 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
